// File: rtl/hls_run_sequencer.sv
// Run-control sequencer for an HLS accelerator with a start_port/done_port handshake.
// For each run it resets the accelerator, pulses start, times the run and emits one result record.
// Optional abort input: define HLS_RUN_SEQUENCER_ABORT_EN.
module hls_run_sequencer #(
  parameter int CYC_W            = 32,
  parameter int TIMEOUT_CYCLES   = 200000000,
  parameter int ACC_RESET_CYCLES = 2,
  parameter int RUN_W            = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [RUN_W-1:0] cmd_runs,
  output logic             cmd_ready,
  output logic             busy,
  output logic             acc_reset,
  output logic             acc_start_port,
  input  logic             acc_done_port,
`ifdef HLS_RUN_SEQUENCER_ABORT_EN
  input  logic             abort,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_status,
  output logic [CYC_W-1:0] res_cycles,
  output logic [RUN_W-1:0] res_index
);

  localparam int RST_W = (ACC_RESET_CYCLES > 1) ? $clog2(ACC_RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST    = RST_W'(ACC_RESET_CYCLES - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_VAL = CYC_W'(TIMEOUT_CYCLES);
  localparam logic [CYC_W-1:0] CYC_ONE     = CYC_W'(1);
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_ABORT   = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_ACC_RST, S_START, S_RUN, S_REPORT} state_t;

  state_t           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             acc_reset_q, acc_reset_d;
  logic             acc_start_q, acc_start_d;
  logic             res_valid_q, res_valid_d;
  logic [1:0]       res_status_q, res_status_d;
  logic [CYC_W-1:0] res_cycles_q, res_cycles_d;
  logic [RUN_W-1:0] res_index_q, res_index_d;
  logic [RUN_W-1:0] remaining_q, remaining_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;

  logic             abort_w;
  logic             rep_en;
  logic [1:0]       rep_status;
  logic [CYC_W-1:0] rep_cycles;
  logic [CYC_W-1:0] cnt_inc;

`ifdef HLS_RUN_SEQUENCER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign cnt_inc = cnt_q + CYC_ONE;

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    busy_d       = busy_q;
    acc_reset_d  = acc_reset_q;
    acc_start_d  = 1'b0;
    res_valid_d  = res_valid_q;
    res_status_d = res_status_q;
    res_cycles_d = res_cycles_q;
    res_index_d  = res_index_q;
    remaining_d  = remaining_q;
    rst_cnt_d    = rst_cnt_q;
    cnt_d        = cnt_q;
    rep_en       = 1'b0;
    rep_status   = ST_OK;
    rep_cycles   = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q && (cmd_runs != '0)) begin
          state_d     = S_ACC_RST;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          acc_reset_d = 1'b0;
          remaining_d = cmd_runs;
          res_index_d = '0;
          rst_cnt_d   = '0;
        end
      end
      S_ACC_RST: begin
        if (abort_w) begin
          rep_en     = 1'b1;
          rep_status = ST_ABORT;
        end else if (rst_cnt_q == RST_LAST) begin
          state_d     = S_START;
          acc_reset_d = 1'b1;
          acc_start_d = 1'b1;
          cnt_d       = CYC_ONE;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      S_START: begin
        if (acc_done_port) begin
          rep_en     = 1'b1;
          rep_cycles = CYC_ONE;
        end else if (abort_w) begin
          rep_en     = 1'b1;
          rep_status = ST_ABORT;
          rep_cycles = cnt_q;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // done takes priority over both abort and the watchdog
        if (acc_done_port) begin
          rep_en     = 1'b1;
          rep_cycles = cnt_inc;
        end else if (abort_w) begin
          rep_en     = 1'b1;
          rep_status = ST_ABORT;
          rep_cycles = cnt_q;
        end else if (cnt_inc == TIMEOUT_VAL) begin
          rep_en     = 1'b1;
          rep_status = ST_TIMEOUT;
          rep_cycles = TIMEOUT_VAL;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          remaining_d = remaining_q - RUN_W'(1);
          if ((res_status_q != ST_OK) || (remaining_q == RUN_W'(1))) begin
            state_d     = S_IDLE;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
            acc_reset_d = 1'b1;
          end else begin
            state_d     = S_ACC_RST;
            res_index_d = res_index_q + RUN_W'(1);
            acc_reset_d = 1'b0;
            rst_cnt_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An aborted run keeps the accelerator in reset while its record waits.
    if (rep_en) begin
      state_d      = S_REPORT;
      res_valid_d  = 1'b1;
      res_status_d = rep_status;
      res_cycles_d = rep_cycles;
      acc_reset_d  = (rep_status != ST_ABORT);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      acc_reset_q  <= 1'b1;
      acc_start_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_status_q <= '0;
      res_cycles_q <= '0;
      res_index_q  <= '0;
      remaining_q  <= '0;
      rst_cnt_q    <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      acc_reset_q  <= acc_reset_d;
      acc_start_q  <= acc_start_d;
      res_valid_q  <= res_valid_d;
      res_status_q <= res_status_d;
      res_cycles_q <= res_cycles_d;
      res_index_q  <= res_index_d;
      remaining_q  <= remaining_d;
      rst_cnt_q    <= rst_cnt_d;
      cnt_q        <= cnt_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign acc_reset      = acc_reset_q;
  assign acc_start_port = acc_start_q;
  assign res_valid      = res_valid_q;
  assign res_status     = res_status_q;
  assign res_cycles     = res_cycles_q;
  assign res_index      = res_index_q;

endmodule

// File: doc/hls_run_sequencer.md
Name: hls_run_sequencer

Overview:
Sequences repeated invocations of an HLS-generated accelerator that uses a start_port/done_port handshake. Per run it:
- applies the accelerator's active-low reset,
- pulses start_port,
- waits for done_port and counts cycles,
- enforces a watchdog,
- emits one result record.

It is the synthesizable replacement for the simulation run-control loop. It sits between a host command interface and the accelerator's control pins.

Parameters:
CYC_W, 32, width of the cycle counter and res_cycles.
TIMEOUT_CYCLES, 200000000, watchdog limit in cycles per run (must be >= 2 and < 2^CYC_W).
ACC_RESET_CYCLES, 2, cycles acc_reset is held low before each start (>= 1).
RUN_W, 16, width of the run-count and run-index fields.

Ports:
clock  in  1  single system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  host requests a batch
cmd_runs  in  RUN_W  number of runs in the batch (0 = no-op)
cmd_ready  out  1  high only in IDLE
busy  out  1  high in any state other than IDLE
acc_reset  out  1  accelerator reset, active-low
acc_start_port  out  1  one-cycle start pulse to the accelerator
acc_done_port  in  1  accelerator completion
res_valid  out  1  result record valid
res_ready  in  1  consumer accepts the record
res_status  out  2  0 = OK, 1 = TIMEOUT, 2 = ABORT, 3 = reserved
res_cycles  out  CYC_W  cycles for this run
res_index  out  RUN_W  0-based run number within the batch

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, cmd_ready=1, busy=0, acc_reset=1, acc_start_port=0, res_valid=0, res_status=0, res_cycles=0, res_index=0.
- IDLE:
  - The command is accepted on cmd_valid & cmd_ready.
  - If cmd_runs == 0, stay in IDLE with no outputs. Otherwise latch remaining=cmd_runs, res_index=0, and go to ACC_RST.
- ACC_RST:
  - acc_reset=0 for exactly ACC_RESET_CYCLES cycles, then go to START.
  - acc_reset returns to 1 in the START cycle.
- START:
  - acc_start_port=1 for exactly one cycle; the cycle counter is loaded with 1.
  - If acc_done_port=1 in this cycle, capture cycles=1, status OK, and go to REPORT. Otherwise go to RUN.
- RUN, evaluated each cycle:
  - Done: if acc_done_port=1, res_cycles=counter+1, status OK, go to REPORT.
  - Timeout: else if counter+1 == TIMEOUT_CYCLES, res_cycles=TIMEOUT_CYCLES, status TIMEOUT, go to REPORT.
  - Otherwise counter increments.
  - If done and timeout coincide, done wins.
  - The counter never wraps, because TIMEOUT_CYCLES < 2^CYC_W.
  - Cycle definition: res_cycles counts every cycle from the start-pulse cycle through the first cycle done is sampled high, inclusive.
- REPORT:
  - res_valid=1; the record is held stable until res_ready.
  - On the handshake, res_valid drops the next cycle and remaining decrements.
  - If status != OK or remaining becomes 0, go to IDLE.
  - Otherwise res_index increments and the sequencer goes to ACC_RST.
  - res_ready may be high on the first REPORT cycle, giving a 1-cycle REPORT.
- Batch termination: a TIMEOUT ends the batch; the remaining runs are not executed and not reported.
- acc_done_port is ignored outside START/RUN.
- cmd_valid is ignored while busy.
- Back-to-back batches: cmd_ready rises the cycle after the final record handshake.
- Reset mid-operation: immediate return to reset values. acc_reset returns to 1 and no result is emitted for the interrupted run.
- Latency, first start after command acceptance: ACC_RESET_CYCLES+1 cycles.

Optional Feature:
Macro: HLS_RUN_SEQUENCER_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort=1 in ACC_RST, START or RUN immediately ends the run: status ABORT, res_cycles = counter value at that cycle (0 if in ACC_RST), go to REPORT, then IDLE.
  - acc_reset is driven low during REPORT after an abort, to quiesce the accelerator.
  - abort in IDLE or REPORT is ignored.
  - abort and done in the same RUN cycle: done wins.
- When undefined: no abort port, and status code 2 is never produced.

Test Plan:
- Single run, done asserted 10 cycles after the start cycle, res_ready tied high -> acc_reset low for 2 cycles, one start pulse, one record {OK, 11, index 0}, cmd_ready high again.
- cmd_runs=3, done latencies 5, 1 and 0 (done already high in START), res_ready tied high -> records {OK,6,0}, {OK,2,1}, {OK,1,2}; acc_reset pulses low before each start.
- TIMEOUT_CYCLES=20, done never asserted, cmd_runs=4 -> single record {TIMEOUT, 20, 0}, then IDLE; only one start pulse issued.
- res_ready held low 7 cycles in REPORT -> res_valid and fields stable throughout, no new start until the handshake; cmd_valid pulsed while busy is ignored.
- Reset asserted during RUN -> next cycle all outputs at reset values, no res_valid; new batch after reset runs normally. cmd_runs=0 -> no start pulse, cmd_ready stays high.
- ABORT_EN build: abort at counter=4 in RUN -> record {ABORT, 4, index}, acc_reset low in REPORT, IDLE afterwards; abort coinciding with done -> record {OK}.
